uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one UART TX serializer among NUM_REQ byte producers (e.g. the RX loopback, status reporter and command responder).
- Selects a requester and loads its byte and parity setting into the TX datapath.
- Issues a one-cycle data_valid to the TX, then tracks tx_busy until the frame completes before granting again.
- Sits between the requesting blocks and the UART TX top in the UART subsystem.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width sent to TX
ID_WIDTH, 2, width of owner index; 2**ID_WIDTH >= NUM_REQ
TIMEOUT_CYC, 16, busy-rise timeout in clk cycles (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request, level, held until gnt
req_data  in  NUM_REQ*DATA_WIDTH  packed bytes, slice i belongs to req[i]; stable while req[i]=1
par_en_cfg  in  NUM_REQ  per-requester parity enable forwarded to TX
gnt  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted
tx_p_data  out  DATA_WIDTH  byte to TX
tx_par_en  out  1  parity enable to TX
tx_data_valid  out  1  one-cycle load strobe to TX
tx_busy  in  1  TX serializer busy (high for whole frame)
owner  out  ID_WIDTH  index of current/last granted requester
arb_busy  out  1  high whenever state != IDLE
tx_timeout  out  1  one-cycle pulse on busy-rise timeout (0 without macro)

Behaviour:
- Reset (rst=0, async): state IDLE, rr pointer ptr=0.
  - All outputs 0: gnt, tx_p_data, tx_par_en, tx_data_valid, owner, arb_busy, tx_timeout.
- All outputs are registered.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If |req and tx_busy=0, pick the first set req[i] searching ptr, ptr+1, ... wrapping mod NUM_REQ, then go to LOAD.
  - If tx_busy=1, stay in IDLE and grant nothing.
- Entering LOAD (edge N+1 after request seen at cycle N):
  - Load tx_p_data from req_data slice i, tx_par_en from par_en_cfg[i], and owner from i.
  - Assert gnt[i] and tx_data_valid; both are high for exactly this one cycle.
- LOAD -> WAIT_BUSY unconditionally.
- WAIT_BUSY: tx_busy=1 -> WAIT_DONE, else stay.
- WAIT_DONE: tx_busy=0 -> IDLE, with ptr <= (owner+1) mod NUM_REQ; else stay.
- tx_p_data and tx_par_en hold stable from LOAD until the next LOAD. owner holds until the next grant.
- Latency: req rise in IDLE -> gnt/tx_data_valid in 1 cycle. Minimum IDLE-to-IDLE cycle is 4 clocks plus the frame length.
- Fairness: with all req high and ptr=0, grant order is 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 frames.
- Requesters must drop req within 1 cycle of gnt. A req still high when the arbiter returns to IDLE is a new request, arbitrated after the others due to the ptr move.
- req dropping before gnt: the request is silently withdrawn; no gnt is issued.
- ptr wrap: owner=NUM_REQ-1 -> ptr=0.
- Reset mid-operation: immediate return to IDLE/reset values. No gnt or tx_data_valid pulse is produced by reset release.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined: a counter clears on entering WAIT_BUSY and increments each cycle there. When it reaches TIMEOUT_CYC with tx_busy still 0:
  - pulse tx_timeout for 1 cycle;
  - go to IDLE;
  - advance ptr as on normal completion.
- Not defined: no counter is built, tx_timeout is tied 0, and WAIT_BUSY waits indefinitely.

Test Plan:
- Reset, then req=4'b0010, req_data slice1=8'hA5, par_en_cfg[1]=1 -> next cycle gnt=4'b0010, tx_data_valid=1, tx_p_data=A5, tx_par_en=1, owner=1. Drive tx_busy high for 10 cycles -> return to IDLE, arb_busy=0.
- req=4'b1111 held (each req re-raised after gnt) with the TX model busy 5 cycles per frame -> grant order 0,1,2,3,0; exactly one gnt bit high per frame.
- Last owner=3, req=4'b1001 -> grant goes to 0 (ptr wrap), then to 3.
- tx_busy=1 in IDLE with req=4'b0001 -> no gnt until tx_busy=0, then gnt 1 cycle later.
- Assert rst mid-WAIT_DONE -> all outputs 0 immediately. After release with req=0, no pulses.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, tx_busy never rises -> tx_timeout pulses 16 cycles after entering WAIT_BUSY, state returns to IDLE, and the next grant goes to owner+1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte producers share one UART TX serializer; optional busy-rise timeout under UART_ARB_TIMEOUT_EN.
// Latency: a request seen in IDLE produces gnt/tx_data_valid one clock later. All outputs are registered.
// Backpressure: nothing is granted while tx_busy is high, and the next grant waits until the current TX frame completes.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ID_WIDTH    = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            par_en_cfg,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_par_en,
    output logic                          tx_data_valid,
    input  logic                          tx_busy,
    output logic [ID_WIDTH-1:0]           owner,
    output logic                          arb_busy,
    output logic                          tx_timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (2**ID_WIDTH) < NUM_REQ || TIMEOUT_CYC < 1) begin : g_param_err
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] pick_idx;
    logic                pick_vld;
    logic [ID_WIDTH:0]   rr_sum;
    logic [ID_WIDTH-1:0] rr_cand;
    logic [ID_WIDTH-1:0] next_ptr;
    logic [DATA_WIDTH-1:0] req_byte [NUM_REQ];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;
`endif

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_byte[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan from the farthest candidate back to ptr so the closest set request wins last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        rr_sum   = '0;
        rr_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            rr_sum = {1'b0, ptr} + (ID_WIDTH+1)'(k);
            if (rr_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (ID_WIDTH+1)'(NUM_REQ);
            end
            rr_cand = rr_sum[ID_WIDTH-1:0];
            if (req[rr_cand]) begin
                pick_vld = 1'b1;
                pick_idx = rr_cand;
            end
        end
    end

    assign next_ptr = (owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ptr           <= '0;
            gnt           <= '0;
            tx_p_data     <= '0;
            tx_par_en     <= 1'b0;
            tx_data_valid <= 1'b0;
            owner         <= '0;
            arb_busy      <= 1'b0;
            tx_timeout    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            gnt           <= '0;
            tx_data_valid <= 1'b0;
            tx_timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld && !tx_busy) begin
                        state         <= LOAD;
                        arb_busy      <= 1'b1;
                        gnt           <= NUM_REQ'(1) << pick_idx;
                        tx_data_valid <= 1'b1;
                        tx_p_data     <= req_byte[pick_idx];
                        tx_par_en     <= par_en_cfg[pick_idx];
                        owner         <= pick_idx;
                    end
                end
                LOAD: begin
                    state <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        // TX never acknowledged the load: drop the byte and move on fairly.
                        state      <= IDLE;
                        arb_busy   <= 1'b0;
                        tx_timeout <= 1'b1;
                        ptr        <= next_ptr;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                        ptr      <= next_ptr;
                    end
                end
                default: begin
                    state    <= IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter in its default build (timeout feature disabled).
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  par_en_cfg;
    logic [3:0]  gnt;
    logic [7:0]  tx_p_data;
    logic        tx_par_en;
    logic        tx_data_valid;
    logic        tx_busy;
    logic [1:0]  owner;
    logic        arb_busy;
    logic        tx_timeout;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(8), .ID_WIDTH(2), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .par_en_cfg(par_en_cfg),
        .gnt(gnt), .tx_p_data(tx_p_data), .tx_par_en(tx_par_en), .tx_data_valid(tx_data_valid),
        .tx_busy(tx_busy), .owner(owner), .arb_busy(arb_busy), .tx_timeout(tx_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Waits for a grant, plays a TX frame of busy_cyc cycles, optionally re-raises the request.
    task automatic run_frame(input int busy_cyc, input bit reraise,
                             output logic [3:0] g, output logic [7:0] d);
        g = '0;
        d = '0;
        for (int i = 0; i < 20 && g == 4'b0; i++) begin
            @(negedge clk);
            if (gnt != 4'b0) begin
                g = gnt;
                d = tx_p_data;
            end
        end
        chk("gnt_seen", {31'b0, g != 4'b0}, 32'd1);
        req     = req & ~g;
        tx_busy = 1'b1;
        @(negedge clk);
        if (reraise) req = req | g;
        repeat (busy_cyc - 1) @(negedge clk);
        tx_busy = 1'b0;
        for (int i = 0; i < 10 && arb_busy; i++) @(negedge clk);
        chk("idle_seen", {31'b0, arb_busy}, 32'd0);
    endtask

    logic [3:0] g;
    logic [7:0] d;
    logic [7:0] exp_d [4];
    logic [4:0] seen;

    initial begin
        rst        = 1'b0;
        req        = '0;
        req_data   = {8'h44, 8'h33, 8'hA5, 8'h11};
        par_en_cfg = 4'b0010;
        tx_busy    = 1'b0;
        exp_d      = '{8'h11, 8'hA5, 8'h33, 8'h44};
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_dv", tx_data_valid, 0);
        chk("rst_data", tx_p_data, 0);
        chk("rst_par", tx_par_en, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_timeout", tx_timeout, 0);
        rst = 1'b1;

        // Single request from requester 1
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        chk("t1_gnt", gnt, 4'b0010);
        chk("t1_dv", tx_data_valid, 1);
        chk("t1_data", tx_p_data, 8'hA5);
        chk("t1_par", tx_par_en, 1);
        chk("t1_owner", owner, 1);
        chk("t1_busy", arb_busy, 1);
        req     = '0;
        tx_busy = 1'b1;
        @(negedge clk);
        chk("t1_gnt_pulse", gnt, 0);
        chk("t1_dv_pulse", tx_data_valid, 0);
        chk("t1_busy_hold", arb_busy, 1);
        repeat (9) @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
        chk("t1_idle", arb_busy, 0);
        chk("t1_data_hold", tx_p_data, 8'hA5);
        chk("t1_owner_hold", owner, 1);

        // All requesting from ptr=0: strict rotation
        do_reset();
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            run_frame(5, 1'b1, g, d);
            chk("rr_gnt", g, 4'b0001 << (f % 4));
            chk("rr_data", d, exp_d[f % 4]);
        end
        req = '0;

        // Pointer wrap after owner 3
        req = 4'b1000;
        run_frame(3, 1'b0, g, d);
        chk("wrap_pre", g, 4'b1000);
        req = 4'b1001;
        run_frame(3, 1'b0, g, d);
        chk("wrap_first", g, 4'b0001);
        run_frame(3, 1'b0, g, d);
        chk("wrap_second", g, 4'b1000);
        chk("wrap_owner", owner, 3);

        // TX busy in IDLE blocks granting
        tx_busy = 1'b1;
        req     = 4'b0001;
        seen    = '0;
        repeat (5) begin
            @(negedge clk);
            seen[3:0] = seen[3:0] | gnt;
        end
        chk("busy_block", seen, 0);
        tx_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_gnt", gnt, 4'b0001);
        chk("busy_release_data", tx_p_data, 8'h11);

        // Reset in the middle of WAIT_DONE
        req     = '0;
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_busy", arb_busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_all", {tx_p_data, tx_par_en, owner, arb_busy, gnt, tx_data_valid, tx_timeout}, 0);
        tx_busy = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        seen = '0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | {tx_data_valid, gnt};
        end
        chk("post_rst_quiet", seen, 0);

        // Request withdrawn before it could be granted
        tx_busy = 1'b1;
        req     = 4'b0010;
        repeat (2) @(negedge clk);
        req     = '0;
        tx_busy = 1'b0;
        seen    = '0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | {tx_data_valid, gnt};
        end
        chk("withdraw_quiet", seen, 0);
        chk("withdraw_idle", arb_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
